// File: rtl/uart_cmd_wrapper_pkg.sv
// Shared constants and state encodings for the UART command front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_cmd_wrapper_pkg;

    localparam logic [7:0] POS_ACK = 8'hA5;
    localparam logic [7:0] NEG_ACK = 8'h5A;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_TXING
    } tx_state_t;

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } asm_state_t;

endpackage

// File: rtl/uart_byte_io.sv
// 8N1 byte receiver (2-flop synchronised, mid-bit sampling) and byte transmitter.
// Latency: byte_rdy 1 clk after mid-stop sample; tx_done 10*BAUD_DIV+1 clks after trmt.
// Backpressure: none; trmt while transmitting is ignored, byte_rdy is a one-cycle pulse.
module uart_byte_io
    import uart_cmd_wrapper_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       byte_rdy,
    output logic       rx_busy,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

    logic            rx_sync1, rx_sync2, rx_prev;
    logic            rx_fall;
    rx_state_t       rx_state;
    logic [BW-1:0]   rx_baud;
    logic [3:0]      rx_bits;
    logic [7:0]      rx_shift;

    tx_state_t       tx_state;
    logic [BW-1:0]   tx_baud;
    logic [3:0]      tx_bits;
    logic [9:0]      tx_shift;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle-high preset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= rx;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync2;
    assign rx_busy = (rx_state != RX_IDLE);

    // Receiver: the edge-detect cycle counts as the first clock of the start bit,
    // so the half-bit sample lands at the true bit centre despite the synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            byte_rdy <= 1'b0;
        end else begin
            byte_rdy <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_baud <= BW'(1);
                    rx_bits <= '0;
                    if (rx_fall) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_baud == HALF_LAST) begin
                        rx_baud  <= '0;
                        rx_state <= rx_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_sync2, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 1'b1;
                        if (rx_bits == 4'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_baud == BAUD_LAST) begin
                        rx_baud  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync2) begin
                            byte_rdy <= 1'b1;
                            rx_data  <= rx_shift;
                        end
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Transmitter: tx is a flop so each bit is held exactly BAUD_DIV clocks from the load edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bits  <= '0;
            tx_shift <= '1;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_baud <= '0;
                    tx_bits <= '0;
                    if (trmt) begin
                        tx_shift <= {1'b1, tx_data, 1'b0};
                        tx       <= 1'b0;
                        tx_done  <= 1'b0;
                        tx_state <= TX_TXING;
                    end
                end
                TX_TXING: begin
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud <= '0;
                        if (tx_bits == 4'd9) begin
                            tx_state <= TX_IDLE;
                            tx       <= 1'b1;
                            tx_done  <= 1'b1;
                        end else begin
                            tx_bits  <= tx_bits + 1'b1;
                            tx_shift <= {1'b1, tx_shift[9:1]};
                            tx       <= tx_shift[1];
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two received bytes (high first) into a 16-bit command; serialises response bytes.
// Latency: cmd_rdy 1 clk after low byte's stop sample (~9.5*BAUD_DIV+3 from its start edge).
// Backpressure: none; a new command overwrites cmd even while cmd_rdy is still set.
module uart_cmd_wrapper
    import uart_cmd_wrapper_pkg::*;
#(
    parameter int BAUD_DIV   = 5208,
    parameter int IB_TIMEOUT = 2**20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int TW = $clog2(IB_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(IB_TIMEOUT);

    logic [7:0]    rx_data;
    logic          byte_rdy;
    logic          rx_busy;
    asm_state_t    asm_state;
    logic [7:0]    hi_byte;
    logic [TW-1:0] to_cnt;
    logic          cmd_set;

    uart_byte_io #(
        .BAUD_DIV (BAUD_DIV)
    ) u_io (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .tx       (TX),
        .rx_data  (rx_data),
        .byte_rdy (byte_rdy),
        .rx_busy  (rx_busy),
        .tx_data  (resp),
        .trmt     (trmt),
        .tx_done  (tx_done)
    );

    assign cmd_set = (asm_state == WAIT_LO) && byte_rdy;

    // Command framing: high byte parks in hi_byte; a stalled low byte times out so framing resyncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state <= WAIT_HI;
            hi_byte   <= '0;
            to_cnt    <= '0;
            cmd       <= '0;
        end else begin
            case (asm_state)
                WAIT_HI: begin
                    to_cnt <= '0;
                    if (byte_rdy) begin
                        hi_byte   <= rx_data;
                        asm_state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (byte_rdy) begin
                        cmd       <= {hi_byte, rx_data};
                        asm_state <= WAIT_HI;
                    end else if (!rx_busy) begin
                        // Counter only runs while the line is idle; a byte in flight freezes it.
                        if (to_cnt >= TO_LIMIT) begin
                            hi_byte   <= '0;
                            asm_state <= WAIT_HI;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                default: asm_state <= WAIT_HI;
            endcase
        end
    end

    // cmd_rdy: a new command takes priority over a same-cycle acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_rdy <= 1'b0;
        end else if (cmd_set) begin
            cmd_rdy <= 1'b1;
        end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
        end
    end

endmodule
